// File: rtl/rgb_video_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rgb_video_pipe
// Purpose  : RGB video pipeline stage. Delays the parallel video bus by DELAY
//            pixel clocks and measures incoming frame geometry (active width,
//            height, line-length consistency). Optional colour-bar pattern
//            substitution is compiled in with the RGB_PIPE_PATTERN_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_video_pipe #(
    parameter int DATA_W    = 8,
    parameter int DELAY     = 1,
    parameter int CNT_W     = 12,
    parameter int BAR_SHIFT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rgb_in_vsync,
    input  logic              rgb_in_hsync,
    input  logic              rgb_in_de,
    input  logic [DATA_W-1:0] rgb_in_data_r,
    input  logic [DATA_W-1:0] rgb_in_data_g,
    input  logic [DATA_W-1:0] rgb_in_data_b,
    output logic              rgb_out_vsync,
    output logic              rgb_out_hsync,
    output logic              rgb_out_de,
    output logic [DATA_W-1:0] rgb_out_data_r,
    output logic [DATA_W-1:0] rgb_out_data_g,
    output logic [DATA_W-1:0] rgb_out_data_b,
    input  logic              pattern_req,
    output logic [CNT_W-1:0]  frame_width,
    output logic [CNT_W-1:0]  frame_height,
    output logic              frame_valid,
    output logic              line_err
);

    localparam int c_PIPE_W = 3 + 3 * DATA_W;

    // Edge detection history
    logic             r_de_d;
    logic             r_vs_d;

    // Measurement state
    logic [CNT_W-1:0] r_px;
    logic [CNT_W-1:0] r_ln;
    logic [CNT_W-1:0] r_line_len;
    logic             r_bad;
    logic             r_synced;
    logic [CNT_W-1:0] r_frame_width;
    logic [CNT_W-1:0] r_frame_height;
    logic             r_frame_valid;
    logic             r_line_err;

    // Data feeding the delay line (pattern or pass-through)
    logic [DATA_W-1:0] w_data_r;
    logic [DATA_W-1:0] w_data_g;
    logic [DATA_W-1:0] w_data_b;

    logic             w_line_end;
    logic             w_frame_start;
    logic             w_len_mismatch;
    logic [CNT_W-1:0] w_ln_after;
    logic [CNT_W-1:0] w_len_after;
    logic             w_bad_after;

    assign w_line_end     = r_de_d & ~rgb_in_de;
    assign w_frame_start  = ~r_vs_d & rgb_in_vsync;
    assign w_len_mismatch = w_line_end && (r_ln != '0) && (r_px != r_line_len);

    // State as it stands after the line end is applied; a frame boundary on
    // the same cycle closes the frame using these values, so the last line
    // still counts in the frame it belongs to.
    assign w_ln_after  = (w_line_end && (r_ln != '1)) ? r_ln + CNT_W'(1) : r_ln;
    assign w_len_after = w_line_end ? r_px : r_line_len;
    assign w_bad_after = r_bad | w_len_mismatch;

    // Previous-cycle de and vsync for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_de_d <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_de_d <= rgb_in_de;
            r_vs_d <= rgb_in_vsync;
        end
    end

    // Saturating active-pixel counter, cleared after each line end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_px <= '0;
        end else if (w_line_end) begin
            r_px <= '0;
        end else if (rgb_in_de && (r_px != '1)) begin
            r_px <= r_px + CNT_W'(1);
        end
    end

    // Line/frame bookkeeping and registered geometry report
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ln           <= '0;
            r_line_len     <= '0;
            r_bad          <= 1'b0;
            r_synced       <= 1'b0;
            r_frame_width  <= '0;
            r_frame_height <= '0;
            r_frame_valid  <= 1'b0;
            r_line_err     <= 1'b0;
        end else begin
            r_line_err <= w_len_mismatch;
            if (w_frame_start) begin
                // The first boundary after reset only arms measurement; the
                // partial frame before it is discarded.
                if (r_synced) begin
                    r_frame_width  <= w_len_after;
                    r_frame_height <= w_ln_after;
                    r_frame_valid  <= !w_bad_after && (w_ln_after != '0);
                end
                r_ln       <= '0;
                r_line_len <= '0;
                r_bad      <= 1'b0;
                r_synced   <= 1'b1;
            end else begin
                r_ln       <= w_ln_after;
                r_line_len <= w_len_after;
                r_bad      <= w_bad_after;
            end
        end
    end

`ifdef RGB_PIPE_PATTERN_EN
    logic       r_pat_active;
    logic [2:0] w_bar;

    assign w_bar = r_px[BAR_SHIFT+2:BAR_SHIFT];

    // Pattern request takes effect only at frame boundaries
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat_active <= 1'b0;
        end else if (w_frame_start) begin
            r_pat_active <= pattern_req;
        end
    end

    // Colour-bar substitution: bar index picks R/G/B full-scale components
    always_comb begin
        w_data_r = rgb_in_data_r;
        w_data_g = rgb_in_data_g;
        w_data_b = rgb_in_data_b;
        if (r_pat_active) begin
            w_data_r = (rgb_in_de && w_bar[2]) ? {DATA_W{1'b1}} : '0;
            w_data_g = (rgb_in_de && w_bar[1]) ? {DATA_W{1'b1}} : '0;
            w_data_b = (rgb_in_de && w_bar[0]) ? {DATA_W{1'b1}} : '0;
        end
    end
`else
    localparam int c_unused_bar_shift = BAR_SHIFT;
    logic w_unused_pattern_req;

    assign w_unused_pattern_req = pattern_req;
    assign w_data_r             = rgb_in_data_r;
    assign w_data_g             = rgb_in_data_g;
    assign w_data_b             = rgb_in_data_b;
`endif

    logic [c_PIPE_W-1:0] w_stage_in;
    logic [c_PIPE_W-1:0] r_pipe [DELAY];

    assign w_stage_in = {rgb_in_vsync, rgb_in_hsync, rgb_in_de,
                         w_data_r, w_data_g, w_data_b};

    // DELAY-stage shift register carrying sync, de and pixel data together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DELAY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int i = 1; i < DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {rgb_out_vsync, rgb_out_hsync, rgb_out_de,
            rgb_out_data_r, rgb_out_data_g, rgb_out_data_b} = r_pipe[DELAY-1];

    assign frame_width  = r_frame_width;
    assign frame_height = r_frame_height;
    assign frame_valid  = r_frame_valid;
    assign line_err     = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_rgb_video_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_video_pipe
// Purpose  : Self-checking bench for rgb_video_pipe (DELAY=3, BAR_SHIFT=0).
//            Reference model works from frame descriptions (line-length lists)
//            and a history of applied inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_video_pipe;

    localparam int DATA_W    = 8;
    localparam int DELAY     = 3;
    localparam int CNT_W     = 12;
    localparam int BAR_SHIFT = 0;
    localparam int PW        = 3 + 3 * DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rgb_in_vsync = 1'b0, rgb_in_hsync = 1'b0, rgb_in_de = 1'b0;
    logic [DATA_W-1:0] rgb_in_data_r = '0, rgb_in_data_g = '0, rgb_in_data_b = '0;
    logic              rgb_out_vsync, rgb_out_hsync, rgb_out_de;
    logic [DATA_W-1:0] rgb_out_data_r, rgb_out_data_g, rgb_out_data_b;
    logic              pattern_req = 1'b0;
    logic [CNT_W-1:0]  frame_width, frame_height;
    logic              frame_valid, line_err;

    int checks   = 0;
    int failures = 0;

    // Model / recording state
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] obs_q [$];
    int            frm_q [$];
    int            pix_q [$];
    int            fall_cycles [$];
    int            cyc_no       = 0;
    int            err_pulses   = 0;
    int            last_err_cyc = -1;
    int            frame_no     = 0;
    bit            m_pat_on     = 1'b0;
    logic          m_prev_vs    = 1'b0;

    rgb_video_pipe #(
        .DATA_W   (DATA_W),
        .DELAY    (DELAY),
        .CNT_W    (CNT_W),
        .BAR_SHIFT(BAR_SHIFT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rgb_in_vsync  (rgb_in_vsync),
        .rgb_in_hsync  (rgb_in_hsync),
        .rgb_in_de     (rgb_in_de),
        .rgb_in_data_r (rgb_in_data_r),
        .rgb_in_data_g (rgb_in_data_g),
        .rgb_in_data_b (rgb_in_data_b),
        .rgb_out_vsync (rgb_out_vsync),
        .rgb_out_hsync (rgb_out_hsync),
        .rgb_out_de    (rgb_out_de),
        .rgb_out_data_r(rgb_out_data_r),
        .rgb_out_data_g(rgb_out_data_g),
        .rgb_out_data_b(rgb_out_data_b),
        .pattern_req   (pattern_req),
        .frame_width   (frame_width),
        .frame_height  (frame_height),
        .frame_valid   (frame_valid),
        .line_err      (line_err)
    );

    always #5 clk = ~clk;

    // One pixel clock: apply inputs, record expected stage word and the
    // observed output sampled on the falling edge.
    task automatic cyc(input logic vs, input logic hs, input logic de, input int pix,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [PW-1:0] e;
        logic [2:0]    bar;
        rgb_in_vsync  = vs;
        rgb_in_hsync  = hs;
        rgb_in_de     = de;
        rgb_in_data_r = r;
        rgb_in_data_g = g;
        rgb_in_data_b = b;
        bar = 3'((pix >> BAR_SHIFT) & 7);
        if (m_pat_on)
            e = {vs, hs, de, (de && bar[2]) ? 8'hFF : 8'h00,
                             (de && bar[1]) ? 8'hFF : 8'h00,
                             (de && bar[0]) ? 8'hFF : 8'h00};
        else
            e = {vs, hs, de, r, g, b};
        if (vs && !m_prev_vs) begin
            frame_no++;
`ifdef RGB_PIPE_PATTERN_EN
            m_pat_on = pattern_req;
`endif
        end
        m_prev_vs = vs;
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
        exp_q.push_back(e);
        frm_q.push_back(frame_no);
        pix_q.push_back(pix);
        obs_q.push_back({rgb_out_vsync, rgb_out_hsync, rgb_out_de,
                         rgb_out_data_r, rgb_out_data_g, rgb_out_data_b});
        if (line_err) begin
            err_pulses++;
            last_err_cyc = cyc_no;
        end
    endtask

    task automatic blank(input logic vs, input logic hs);
        cyc(vs, hs, 1'b0, -1, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Two cycles of vsync high (rising edge on the first if vsync was low)
    task automatic vs_rise();
        blank(1'b1, 1'b0);
        blank(1'b1, 1'b0);
    endtask

    // Lines of a frame body; end_vs merges the last de fall with a vsync rise
    task automatic send_frame(input int lens[$], input bit end_vs);
        blank(1'b0, 1'b0);
        blank(1'b0, 1'b0);
        for (int l = 0; l < lens.size(); l++) begin
            blank(1'b0, 1'b1);
            blank(1'b0, 1'b0);
            for (int p = 0; p < lens[l]; p++)
                cyc(1'b0, 1'b0, 1'b1, p, 8'($urandom), 8'($urandom), 8'($urandom));
            fall_cycles.push_back(cyc_no + 1);
            if (end_vs && (l == lens.size() - 1)) begin
                blank(1'b1, 1'b0);
            end else begin
                blank(1'b0, 1'b0);
                blank(1'b0, 1'b0);
            end
        end
    endtask

    task automatic clear_model();
        exp_q.delete(); obs_q.delete(); frm_q.delete(); pix_q.delete();
        fall_cycles.delete();
        err_pulses = 0; last_err_cyc = -1;
        m_prev_vs = 1'b0; m_pat_on = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        {rgb_in_vsync, rgb_in_hsync, rgb_in_de} = 3'b000;
        {rgb_in_data_r, rgb_in_data_g, rgb_in_data_b} = '0;
        pattern_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        logic [PW-1:0] o;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {rgb_in_vsync, rgb_in_hsync, rgb_in_de} = 3'b111;
            rgb_in_data_r = 8'($urandom) | 8'h01;
            rgb_in_data_g = 8'($urandom);
            rgb_in_data_b = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            o = {rgb_out_vsync, rgb_out_hsync, rgb_out_de,
                 rgb_out_data_r, rgb_out_data_g, rgb_out_data_b};
            checks++;
            if (o !== '0) begin
                failures++;
                $display("FAIL reset_rgb_out[%0d]: got %h expected 0", i, o);
            end
            checks++;
            if ({frame_width, frame_height, frame_valid, line_err} !== '0) begin
                failures++;
                $display("FAIL reset_geometry[%0d]: got w=%0d h=%0d v=%0b e=%0b expected all 0",
                         i, frame_width, frame_height, frame_valid, line_err);
            end
        end
    endtask

    task automatic test_latency();
        logic [PW-1:0] ev;
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 0, 8'h01, 8'h01, 8'h01);
        cyc(1'b0, 1'b0, 1'b1, 1, 8'h02, 8'h02, 8'h02);
        cyc(1'b0, 1'b0, 1'b1, 2, 8'h03, 8'h03, 8'h03);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, -1, 8'h00, 8'h00, 8'h00);
        checks++;
        if (obs_q[2] !== {3'b001, 24'h010101}) begin
            failures++;
            $display("FAIL latency_first: got %h expected %h", obs_q[2], {3'b001, 24'h010101});
        end
        checks++;
        if (obs_q[4][23:0] !== 24'h030303) begin
            failures++;
            $display("FAIL latency_third: got %h expected 030303", obs_q[4][23:0]);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            ev = (i >= DELAY - 1) ? exp_q[i-DELAY+1] : '0;
            checks++;
            if (obs_q[i] !== ev) begin
                failures++;
                $display("FAIL latency_out[%0d]: got %h expected %h", i, obs_q[i], ev);
            end
        end
    endtask

    task automatic test_random_delay();
        logic [PW-1:0] ev;
        do_reset();
        for (int i = 0; i < 150; i++) begin
`ifdef RGB_PIPE_PATTERN_EN
            pattern_req = 1'b0;
`else
            pattern_req = 1'($urandom);
`endif
            cyc(1'($urandom), 1'($urandom), 1'($urandom), -1,
                8'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            ev = (i >= DELAY - 1) ? exp_q[i-DELAY+1] : '0;
            checks++;
            if (obs_q[i] !== ev) begin
                failures++;
                $display("FAIL random_delay[%0d]: got %h expected %h", i, obs_q[i], ev);
            end
        end
    endtask

    task automatic test_geometry();
        int lens[$];
        lens = '{8, 8, 8, 8};
        do_reset();
        vs_rise();
        checks++;
        if ({frame_width, frame_height, frame_valid} !== '0) begin
            failures++;
            $display("FAIL geo_first_vsync: got w=%0d h=%0d v=%0b expected 0 0 0",
                     frame_width, frame_height, frame_valid);
        end
        for (int f = 0; f < 2; f++) begin
            send_frame(lens, 1'b0);
            vs_rise();
            checks++;
            if ({frame_width, frame_height, frame_valid} !== {12'd8, 12'd4, 1'b1}) begin
                failures++;
                $display("FAIL geo_frame%0d: got w=%0d h=%0d v=%0b expected 8 4 1",
                         f + 2, frame_width, frame_height, frame_valid);
            end
        end
        checks++;
        if (err_pulses !== 0) begin
            failures++;
            $display("FAIL geo_no_line_err: got %0d pulses expected 0", err_pulses);
        end
    endtask

    task automatic test_mismatch();
        int lens[$];
        lens = '{8, 8, 8, 7};
        do_reset();
        vs_rise();
        send_frame(lens, 1'b0);
        checks++;
        if (err_pulses !== 1) begin
            failures++;
            $display("FAIL mismatch_pulses: got %0d expected 1", err_pulses);
        end
        checks++;
        if (last_err_cyc !== fall_cycles[fall_cycles.size()-1]) begin
            failures++;
            $display("FAIL mismatch_timing: got cycle %0d expected %0d",
                     last_err_cyc, fall_cycles[fall_cycles.size()-1]);
        end
        vs_rise();
        checks++;
        if ({frame_width, frame_height, frame_valid} !== {12'd7, 12'd4, 1'b0}) begin
            failures++;
            $display("FAIL mismatch_frame: got w=%0d h=%0d v=%0b expected 7 4 0",
                     frame_width, frame_height, frame_valid);
        end
    endtask

    task automatic test_random_geometry();
        int lens[$];
        int n, base, odd, mism, ew;
        bit ev;
        do_reset();
        vs_rise();
        for (int f = 0; f < 6; f++) begin
            n    = $urandom_range(1, 6);
            base = $urandom_range(2, 20);
            lens.delete();
            for (int l = 0; l < n; l++) lens.push_back(base);
            if ($urandom_range(0, 1) == 1) begin
                odd = $urandom_range(0, n - 1);
                lens[odd] = base + $urandom_range(1, 3);
            end
            mism = 0;
            for (int l = 1; l < n; l++) if (lens[l] != lens[l-1]) mism++;
            ew = lens[n-1];
            ev = (mism == 0);
            err_pulses = 0;
            send_frame(lens, 1'b0);
            vs_rise();
            checks++;
            if ({frame_width, frame_height, frame_valid} !== {CNT_W'(ew), CNT_W'(n), ev}) begin
                failures++;
                $display("FAIL rand_geo[%0d]: got w=%0d h=%0d v=%0b expected %0d %0d %0b",
                         f, frame_width, frame_height, frame_valid, ew, n, ev);
            end
            checks++;
            if (err_pulses !== mism) begin
                failures++;
                $display("FAIL rand_line_err[%0d]: got %0d pulses expected %0d", f, err_pulses, mism);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lens[$];
        int two[$];
        lens = '{8, 8, 8, 8};
        two  = '{8, 8};
        do_reset();
        vs_rise();
        send_frame(lens, 1'b0);
        vs_rise();
        checks++;
        if ({frame_width, frame_height, frame_valid} !== {12'd8, 12'd4, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_pre: got w=%0d h=%0d v=%0b expected 8 4 1",
                     frame_width, frame_height, frame_valid);
        end
        send_frame(two, 1'b0);
        for (int p = 0; p < 4; p++) cyc(1'b0, 1'b0, 1'b1, p, 8'hA5, 8'h5A, 8'hC3);
        reset = 1'b0;
        #1;
        checks++;
        if ({rgb_out_vsync, rgb_out_hsync, rgb_out_de, rgb_out_data_r,
             rgb_out_data_g, rgb_out_data_b} !== '0) begin
            failures++;
            $display("FAIL rstmid_rgb_out: got %h expected 0",
                     {rgb_out_de, rgb_out_data_r, rgb_out_data_g, rgb_out_data_b});
        end
        checks++;
        if ({frame_width, frame_height, frame_valid, line_err} !== '0) begin
            failures++;
            $display("FAIL rstmid_geometry: got w=%0d h=%0d v=%0b e=%0b expected all 0",
                     frame_width, frame_height, frame_valid, line_err);
        end
        {rgb_in_vsync, rgb_in_hsync, rgb_in_de} = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        vs_rise();
        checks++;
        if ({frame_width, frame_height, frame_valid} !== '0) begin
            failures++;
            $display("FAIL rstmid_first_vsync: got w=%0d h=%0d v=%0b expected 0 0 0",
                     frame_width, frame_height, frame_valid);
        end
        send_frame(lens, 1'b0);
        vs_rise();
        checks++;
        if ({frame_width, frame_height, frame_valid} !== {12'd8, 12'd4, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_second_vsync: got w=%0d h=%0d v=%0b expected 8 4 1",
                     frame_width, frame_height, frame_valid);
        end
    endtask

    task automatic test_simultaneous();
        int lens[$];
        lens = '{8, 8, 8, 8};
        do_reset();
        vs_rise();
        send_frame(lens, 1'b1);
        checks++;
        if ({frame_width, frame_height, frame_valid} !== {12'd8, 12'd4, 1'b1}) begin
            failures++;
            $display("FAIL simul_merged: got w=%0d h=%0d v=%0b expected 8 4 1",
                     frame_width, frame_height, frame_valid);
        end
        vs_rise();
        send_frame(lens, 1'b0);
        vs_rise();
        checks++;
        if ({frame_width, frame_height, frame_valid} !== {12'd8, 12'd4, 1'b1}) begin
            failures++;
            $display("FAIL simul_next: got w=%0d h=%0d v=%0b expected 8 4 1",
                     frame_width, frame_height, frame_valid);
        end
    endtask

`ifdef RGB_PIPE_PATTERN_EN
    task automatic test_pattern();
        int one[$];
        int two[$];
        int cfrm, j;
        logic [PW-1:0] ev;
        one = '{8};
        two = '{8, 8};
        do_reset();
        vs_rise();
        send_frame(one, 1'b0);
        pattern_req = 1'b1;
        send_frame(one, 1'b0);
        vs_rise();
        cfrm = frame_no;
        send_frame(two, 1'b0);
        pattern_req = 1'b0;
        vs_rise();
        send_frame(one, 1'b0);
        for (int i = 0; i < obs_q.size(); i++) begin
            ev = (i >= DELAY - 1) ? exp_q[i-DELAY+1] : '0;
            checks++;
            if (obs_q[i] !== ev) begin
                failures++;
                $display("FAIL pattern_out[%0d]: got %h expected %h", i, obs_q[i], ev);
            end
        end
        j = -1;
        for (int i = 0; i < frm_q.size(); i++)
            if ((j < 0) && (frm_q[i] == cfrm) && (pix_q[i] == 5)) j = i;
        checks++;
        if ((j < 0) || (j + DELAY - 1 >= obs_q.size())) begin
            failures++;
            $display("FAIL pattern_px5: got no sample expected FF00FF");
        end else if (obs_q[j+DELAY-1][23:0] !== 24'hFF00FF) begin
            failures++;
            $display("FAIL pattern_px5: got %h expected FF00FF", obs_q[j+DELAY-1][23:0]);
        end
    endtask
`else
    task automatic test_pattern();
        int lens[$];
        logic [PW-1:0] ev;
        lens = '{8, 8};
        do_reset();
        pattern_req = 1'b1;
        vs_rise();
        send_frame(lens, 1'b0);
        vs_rise();
        send_frame(lens, 1'b0);
        for (int i = 0; i < obs_q.size(); i++) begin
            ev = (i >= DELAY - 1) ? exp_q[i-DELAY+1] : '0;
            checks++;
            if (obs_q[i] !== ev) begin
                failures++;
                $display("FAIL pattern_ignored[%0d]: got %h expected %h", i, obs_q[i], ev);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_random_delay();
        test_geometry();
        test_mismatch();
        test_random_geometry();
        test_reset_mid();
        test_simultaneous();
        test_pattern();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb_video_pipe.md
# rgb_video_pipe

Parametrised RGB video pipeline stage for the DVI test DUT, replacing the plain combinational RGB loopback. It delays the parallel video bus by a configurable number of pixel clocks and measures incoming frame geometry, reporting active width, height and line-length consistency per frame. It can optionally substitute a colour-bar test pattern for the pixel data. It sits between the RGB sink/source interfaces and the TMDS encode path.

## Interface
- DATA_W, 8, bits per colour component
- DELAY, 1, pipeline latency in clocks, legal 1..16
- CNT_W, 12, width of pixel and line counters
- BAR_SHIFT, 4, log2 of colour-bar width in pixels (pattern build only)
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- rgb_in_vsync / rgb_in_hsync / rgb_in_de  in  1 each  input sync and data enable, active-high
- rgb_in_data_r / _g / _b  in  DATA_W each  input pixel components
- rgb_out_vsync / rgb_out_hsync / rgb_out_de  out  1 each  delayed sync and data enable
- rgb_out_data_r / _g / _b  out  DATA_W each  delayed or pattern pixel components
- pattern_req  in  1  request colour-bar output (ignored without macro)
- frame_width  out  CNT_W  active pixels per line of last complete frame
- frame_height  out  CNT_W  active lines of last complete frame
- frame_valid  out  1  last complete frame measured with consistent line lengths
- line_err  out  1  one-cycle pulse on line-length mismatch

## Operation
- Delay line: DELAY register stages on vsync, hsync, de and data. No combinational path from input to output.
- Pixel counter px: increments on each cycle with rgb_in_de=1 and saturates at all-ones. It clears on the cycle after a de falling edge.
- Line end (de 1->0):
  - Latch px into line_len and increment line counter ln (saturating).
  - If a previous line in the same frame exists and px != line_len, pulse line_err and set the frame's bad flag.
- Frame boundary (vsync 0->1):
  - If the synced flag is set: frame_width <= line_len, frame_height <= ln, frame_valid <= (!bad && ln != 0).
  - Then clear ln, bad and line_len, and set synced.
  - The first vsync rising edge after reset only sets synced. The partial frame is discarded, so the outputs are unchanged.
- Simultaneous de falling and vsync rising on the same cycle: process the line end first, then the frame boundary, so the line counts in the closing frame.
- Reset mid-frame: all counters, flags, pipeline stages and outputs go to 0 immediately. Measurement restarts per the synced rule.

## Timing
- Reset values: all rgb_out_* 0, frame_width 0, frame_height 0, frame_valid 0, line_err 0.
- rgb_out_* at cycle t+DELAY equals rgb_in_* at cycle t, when the pattern is inactive.
- line_err is asserted on the cycle after the de falling edge, for exactly one cycle.
- frame_width, frame_height and frame_valid update on the cycle after the vsync rising edge and hold until the next update.

## Configuration
- RGB_PIPE_PATTERN_EN defined:
  - pattern_req is sampled only at vsync rising edges. The active pattern state changes only at frame boundaries.
  - While active, data at de=1 becomes bar b = px[BAR_SHIFT+2:BAR_SHIFT]:
    - R = all-ones if b[2], else 0
    - G = all-ones if b[1], else 0
    - B = all-ones if b[0], else 0
  - Data at de=0 is 0. Sync and de pass unmodified, with pattern data aligned to the same DELAY.
- Macro not defined:
  - The pattern logic is absent and pattern_req is unused.
  - Data is always the pure delayed input.

## Test plan
- Latency: DELAY=3, drive ramp data 0x01,0x02,0x03 with de=1. Required: identical values appear on rgb_out_* 3 cycles later; outputs are 0 during reset.
- Geometry:
  - Send three frames of 4 lines x 8 pixels.
  - After the 1st vsync rise, outputs are unchanged at 0.
  - After the 2nd, frame_width=8, frame_height=4, frame_valid=1.
- Mismatch: one line of 7 pixels within 8-pixel lines. Required: line_err pulses once at that line's end; frame_valid=0 at the next vsync rise.
- Pattern (macro on):
  - BAR_SHIFT=0, pattern_req=1 asserted mid-frame.
  - Current frame passes input unchanged.
  - Next frame, pixel 5 outputs R=0xFF, G=0x00, B=0xFF.
- Reset mid-frame: assert reset after 2 lines of frame 2. Required: all outputs 0 at once; the first vsync rise afterwards leaves frame_valid=0; the second reports correct geometry.
- Simultaneous events: de falls on the same cycle vsync rises at the end of line 4. Required: frame_height=4.
